// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch controller: bus widths,
// flash data width and the FSM state encodings.
package inst_fetch_ctrl_pkg;

  localparam int INST_W      = 32;  // instruction bus width
  localparam int INST_ADDR_W = 32;  // CPU fetch address width
  localparam int FLASH_DW    = 16;  // flash returns one halfword per read

  // Plain constants rather than an enum so older tools and netlists see the
  // same encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RD_LO = 2'd1;
  localparam logic [1:0] ST_RD_HI = 2'd2;

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: a one-entry fetch buffer in front of a
// 16-bit wide flash. A miss reads the two halfwords of the requested word,
// each held on the flash bus for WAIT_CYCLES cycles, while the CPU is
// stalled. Once started, a fetch always runs to completion.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,   // flash cycles per halfword read, 1..15
  parameter int FLASH_AW    = 22   // flash halfword address width
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rom_ce_i,
  input  logic [INST_ADDR_W-1:0] rom_addr_i,
  input  logic                   flush_i,
  output logic [INST_W-1:0]      rom_inst_o,
  output logic                   stall_req_o,
  output logic [FLASH_AW-1:0]    flash_addr_o,
  output logic                   flash_oe_n_o,
  input  logic [FLASH_DW-1:0]    flash_data_i
);

  // A word is two halfwords, so the word address is one bit narrower.
  localparam int WORD_W = FLASH_AW - 1;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]          state_reg;
  logic [3:0]          cnt_reg;
  logic [WORD_W-1:0]   word_reg;   // word being fetched
  logic [FLASH_DW-1:0] lo_reg;     // low halfword staged until the high half arrives
  logic [WORD_W-1:0]   tag_reg;
  logic [INST_W-1:0]   data_reg;
  logic                valid_reg;

  logic [WORD_W-1:0]   addr_word;
  logic                hit;
  logic                last_cycle;
  logic                unused_addr_bits;

  assign addr_word  = rom_addr_i[FLASH_AW:2];
  assign hit        = rom_ce_i & valid_reg & (tag_reg == addr_word);
  assign last_cycle = (cnt_reg == LAST_CNT);

  // Byte offset and address bits beyond the flash are deliberately ignored.
  assign unused_addr_bits = ^{rom_addr_i[INST_ADDR_W-1:FLASH_AW+1], rom_addr_i[1:0]};

  // CPU side: buffer data on hit, stall on any enabled miss.
  always_comb begin
    rom_inst_o  = hit ? data_reg : '0;
    stall_req_o = rom_ce_i & ~hit;
  end

  // Flash side: drive the halfword address only while a read is in progress.
  always_comb begin
    flash_oe_n_o = 1'b1;
    flash_addr_o = '0;
    case (state_reg)
      ST_RD_LO: begin
        flash_oe_n_o = 1'b0;
        flash_addr_o = {word_reg, 1'b0};
      end
      ST_RD_HI: begin
        flash_oe_n_o = 1'b0;
        flash_addr_o = {word_reg, 1'b1};
      end
      default: begin
        flash_oe_n_o = 1'b1;
        flash_addr_o = '0;
      end
    endcase
  end

  // Fetch FSM, wait counter and buffer update; the low halfword is staged
  // separately so the buffer never holds a half-written word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      word_reg  <= '0;
      lo_reg    <= '0;
      tag_reg   <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (flush_i) begin
        valid_reg <= 1'b0;
      end
      case (state_reg)
        ST_IDLE: begin
          if (rom_ce_i && !hit) begin
            word_reg  <= addr_word;
            cnt_reg   <= '0;
            state_reg <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          if (last_cycle) begin
            lo_reg    <= flash_data_i;
            cnt_reg   <= '0;
            state_reg <= ST_RD_HI;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        ST_RD_HI: begin
          if (last_cycle) begin
            data_reg  <= {flash_data_i, lo_reg};
            tag_reg   <= word_reg;
            // A flush on the completion edge wins over the new fill.
            valid_reg <= ~flush_i;
            cnt_reg   <= '0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          cnt_reg   <= '0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
